// File: rtl/spi_reg_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_reg_target
//  Description : SPI mode-0 target that turns 16-bit write frames into five
//                8-bit control registers. Optional macro SPI_READBACK_EN
//                enables register readback on cipo.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_target #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int NREGS = 5;
    localparam int SW    = SYNC_STAGES + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    logic [SW-1:0]          sclk_sync_q;
    logic [SW-1:0]          ncs_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;

    // Index SYNC_STAGES-1 is the synchronized value; the top bit is history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '1;
            copi_sync_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SW-2:0], sclk};
            ncs_sync_q  <= {ncs_sync_q[SW-2:0], ncs};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
        end
    end

    logic sclk_s, sclk_h, ncs_s, ncs_h, copi_s;
    logic sclk_rise, ncs_rise, ncs_fall;
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sclk_h    = sclk_sync_q[SYNC_STAGES];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign ncs_h     = ncs_sync_q[SYNC_STAGES];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_h;
    assign ncs_rise  = ncs_s & ~ncs_h;
    assign ncs_fall  = ~ncs_s & ncs_h;

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        we;
    logic [7:0]  regs_q [NREGS];
    logic [15:0] shift_next;
    logic [6:0]  wr_addr;
    logic        wr_addr_ok;

    assign shift_next = {shift_q[14:0], copi_s};
    assign wr_addr    = shift_q[14:8];
    assign wr_addr_ok = (int'(wr_addr) <= MAX_ADDR) && (wr_addr < 7'(NREGS));

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A chip-select rise beats a coincident sclk edge.
                if (ncs_rise) begin
                    state_d = ST_COMMIT;
                end else if (sclk_rise) begin
                    shift_d = shift_next;
                    if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (cnt_q != 5'd16) begin
                    err_d = 1'b1;
                end else if (shift_q[15] && wr_addr_ok) begin
                    we     = 1'b1;
                    done_d = 1'b1;
`ifdef SPI_READBACK_EN
                end else if (!shift_q[15]) begin
                    done_d = 1'b1;
`endif
                end
                if (ncs_fall) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (we) regs_q[wr_addr[2:0]] <= shift_q[7:0];
        end
    end

`ifdef SPI_READBACK_EN
    logic [7:0] rb_q, rb_d;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       sclk_fall;

    assign sclk_fall = ~sclk_s & sclk_h;
    assign rd_addr   = shift_next[6:0];

    always_comb begin
        rd_data = 8'h00;
        if ((int'(rd_addr) <= MAX_ADDR) && (rd_addr < 7'(NREGS)))
            rd_data = regs_q[rd_addr[2:0]];
    end

    // Loaded after the 8th rising edge; the first falling edge after that
    // keeps the MSB so the controller can sample it on the 9th rising edge.
    always_comb begin
        rb_d = '0;
        if (state_q == ST_SHIFT && !ncs_rise) begin
            rb_d = rb_q;
            if (sclk_rise && cnt_q == 5'd7 && !shift_next[7])
                rb_d = rd_data;
            else if (sclk_fall && cnt_q >= 5'd9 && cnt_q <= 5'd15)
                rb_d = {rb_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rb_q <= '0;
        else        rb_q <= rb_d;
    end

    assign cipo = rb_q[7];
`else
    assign cipo = 1'b0;
`endif

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign frame_done      = done_q;
    assign frame_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_reg_target
//  Description : Randomized scoreboard bench for spi_reg_target.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_target;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_ADDR    = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       copi  = 1'b0;
    logic       ncs   = 1'b1;
    logic       cipo;
    logic [7:0] r0, r1, r2, r3, r4;
    logic       frame_done, frame_err;

    always #5 clk = ~clk;

    spi_reg_target #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(MAX_ADDR)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .cipo            (cipo),
        .en_reg_out_7_0  (r0),
        .en_reg_out_15_8 (r1),
        .en_reg_pwm_7_0  (r2),
        .en_reg_pwm_15_8 (r3),
        .pwm_duty_cycle  (r4),
        .frame_done      (frame_done),
        .frame_err       (frame_err)
    );

    typedef struct packed {
        logic        is_err;
        logic [39:0] regs;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model [5];
    exp_t       exp_q [$];
    exp_t       mon_e;
    logic [39:0] dut_regs;

    assign dut_regs = {r4, r3, r2, r1, r0};

    function automatic logic [39:0] pack_model();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (frame_done || frame_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse actual done=%0b err=%0b required none", frame_done, frame_err);
            end else begin
                mon_e = exp_q.pop_front();
                if (frame_done !== !mon_e.is_err || frame_err !== mon_e.is_err || dut_regs !== mon_e.regs) begin
                    errors++;
                    $display("FAIL pulse_regs actual done=%0b err=%0b regs=%h required err=%0b regs=%h",
                             frame_done, frame_err, dut_regs, mon_e.is_err, mon_e.regs);
                end
            end
        end
    end

    // SCLK = clk/8, MSB first; bits past 16 carry random data.
    task automatic send_frame(input logic [15:0] w, input int nbits, input bit leave_low,
                              output logic [7:0] rb, output bit cipo_seen);
        rb = 8'h00;
        cipo_seen = 1'b0;
        @(negedge clk) ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            copi = (i < 16) ? w[15-i] : 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            if (i >= 8 && i < 16) rb[15-i] = cipo;
            if (cipo !== 1'b0) cipo_seen = 1'b1;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        if (!leave_low) begin
            repeat (4) @(negedge clk);
            ncs = 1'b1;
        end
    endtask

    task automatic do_frame(input logic [15:0] w, input int nbits);
        logic [7:0] rb;
        logic [7:0] exp_rb;
        bit         cs;
        bit         addr_ok;
        exp_t       e;
        addr_ok = int'(w[14:8]) <= MAX_ADDR;
        exp_rb  = addr_ok ? model[w[10:8]] : 8'h00;
        if (nbits != 16) begin
            e.is_err = 1'b1; e.regs = pack_model(); exp_q.push_back(e);
        end else if (w[15] && addr_ok) begin
            model[w[10:8]] = w[7:0];
            e.is_err = 1'b0; e.regs = pack_model(); exp_q.push_back(e);
`ifdef SPI_READBACK_EN
        end else if (!w[15]) begin
            e.is_err = 1'b0; e.regs = pack_model(); exp_q.push_back(e);
`endif
        end
        send_frame(w, nbits, 1'b0, rb, cs);
        repeat (SYNC_STAGES + 2) @(posedge clk);
        #1;
        check("latency_regs", dut_regs, pack_model());
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pulse_timeout actual outstanding=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (6) @(negedge clk);
`ifdef SPI_READBACK_EN
        if (nbits == 16 && !w[15]) check("readback", {32'h0, rb}, {32'h0, exp_rb});
`else
        checks++;
        if (cs) begin
            errors++;
            $display("FAIL cipo_idle actual=1 required=0 frame=%h", w);
        end
        if (exp_rb === 8'hxx) $display("note: unused %h", rb);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rb;
        bit          cs;
        logic [15:0] w;
        int          nb;
        int          lens [5] = '{15, 16, 16, 16, 17};
        for (int i = 0; i < 5; i++) model[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_regs", dut_regs, 40'h0);
        check("reset_cipo", {39'h0, cipo}, 40'h0);
        check("reset_done", {39'h0, frame_done}, 40'h0);
        check("reset_err", {39'h0, frame_err}, 40'h0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        do_frame(16'h80FF, 16);
        do_frame(16'h8480, 16);
        do_frame(16'h8440, 16);
        do_frame(16'h8255, 15);
        do_frame(16'h8255, 17);
        do_frame(16'h90AA, 16);
        do_frame(16'h8337, 16);
        do_frame(16'h0300, 16);
        do_frame(16'h0455, 16);

        for (int a = 0; a < 5; a++) do_frame({1'b1, 7'(a), 8'hA5}, 16);
        send_frame(16'h82C3, 9, 1'b1, rb, cs);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("midframe_reset_regs", dut_regs, pack_model());
        check("midframe_reset_cipo", {39'h0, cipo}, 40'h0);
        ncs = 1'b1;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        do_frame(16'h8312, 16);

        for (int n = 0; n < 40; n++) begin
            w[15]   = ($urandom_range(0, 3) != 0);
            w[14:8] = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 5));
            w[7:0]  = 8'($urandom_range(0, 255));
            nb      = lens[$urandom_range(0, 4)];
            do_frame(w, nb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
